// File: rtl/pp_reducer_if.sv
// rtl/pp_reducer_if.sv - partial-product input and product output handshake bundle
interface pp_reducer_if #(
  parameter int WIDTH = 64
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] pp0,  pp1,  pp2,  pp3,  pp4,  pp5,  pp6,  pp7;
  logic [WIDTH-1:0] pp8,  pp9,  pp10, pp11, pp12, pp13, pp14, pp15;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] product;

  modport slave (
    input  valid_i, ready_i,
    input  pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7,
    input  pp8, pp9, pp10, pp11, pp12, pp13, pp14, pp15,
    output ready_o, valid_o, product
  );

  modport master (
    output valid_i, ready_i,
    output pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7,
    output pp8, pp9, pp10, pp11, pp12, pp13, pp14, pp15,
    input  ready_o, valid_o, product
  );
endinterface

// File: rtl/pp_reducer.sv
// rtl/pp_reducer.sv - 3-stage carry-save reduction and final add of sixteen partial products
module pp_reducer #(
  parameter int WIDTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  pp_reducer_if.slave  bus
);
  typedef logic [WIDTH-1:0] word_t;

  function automatic word_t csa_sum(input word_t a, input word_t b, input word_t c);
    return a ^ b ^ c;
  endfunction

  // The left shift drops the carry out of the top bit, keeping everything modulo 2^WIDTH.
  function automatic word_t csa_carry(input word_t a, input word_t b, input word_t c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  logic  v1, v2, v3;
  logic  en1, en2, en3;
  word_t s1_q [4];
  word_t s2_sum_q, s2_carry_q;
  word_t s3_q;

  word_t l0 [16];
  word_t l1 [11];
  word_t l2 [8];
  word_t l3 [6];
  word_t l4 [4];
  word_t m3 [3];
  word_t s2_sum_d, s2_carry_d;

  // Stage 1 tree: 16 -> 11 -> 8 -> 6 -> 4, leftover rows pass straight through.
  always_comb begin
    l0 = '{bus.pp0,  bus.pp1,  bus.pp2,  bus.pp3,  bus.pp4,  bus.pp5,  bus.pp6,  bus.pp7,
           bus.pp8,  bus.pp9,  bus.pp10, bus.pp11, bus.pp12, bus.pp13, bus.pp14, bus.pp15};
    for (int i = 0; i < 5; i++) begin
      l1[2*i]   = csa_sum  (l0[3*i], l0[3*i+1], l0[3*i+2]);
      l1[2*i+1] = csa_carry(l0[3*i], l0[3*i+1], l0[3*i+2]);
    end
    l1[10] = l0[15];
    for (int i = 0; i < 3; i++) begin
      l2[2*i]   = csa_sum  (l1[3*i], l1[3*i+1], l1[3*i+2]);
      l2[2*i+1] = csa_carry(l1[3*i], l1[3*i+1], l1[3*i+2]);
    end
    l2[6] = l1[9];
    l2[7] = l1[10];
    for (int i = 0; i < 2; i++) begin
      l3[2*i]   = csa_sum  (l2[3*i], l2[3*i+1], l2[3*i+2]);
      l3[2*i+1] = csa_carry(l2[3*i], l2[3*i+1], l2[3*i+2]);
    end
    l3[4] = l2[6];
    l3[5] = l2[7];
    for (int i = 0; i < 2; i++) begin
      l4[2*i]   = csa_sum  (l3[3*i], l3[3*i+1], l3[3*i+2]);
      l4[2*i+1] = csa_carry(l3[3*i], l3[3*i+1], l3[3*i+2]);
    end
  end

  always_comb begin
    m3[0]      = csa_sum  (s1_q[0], s1_q[1], s1_q[2]);
    m3[1]      = csa_carry(s1_q[0], s1_q[1], s1_q[2]);
    m3[2]      = s1_q[3];
    s2_sum_d   = csa_sum  (m3[0], m3[1], m3[2]);
    s2_carry_d = csa_carry(m3[0], m3[1], m3[2]);
  end

  // A stage may load when empty or when its contents move on this cycle.
  assign en3 = ~v3 | bus.ready_i;
  assign en2 = ~v2 | en3;
  assign en1 = ~v1 | en2;

  assign bus.ready_o = en1;
  assign bus.valid_o = v3;
  assign bus.product = s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      s1_q       <= '{default: '0};
      s2_sum_q   <= '0;
      s2_carry_q <= '0;
      s3_q       <= '0;
    end else begin
      if (en1) begin
        v1 <= bus.valid_i;
        if (bus.valid_i) s1_q <= l4;
      end
      if (en2) begin
        v2 <= v1;
        if (v1) begin
          s2_sum_q   <= s2_sum_d;
          s2_carry_q <= s2_carry_d;
        end
      end
      if (en3) begin
        v3 <= v2;
        if (v2) s3_q <= s2_sum_q + s2_carry_q;
      end
    end
  end
endmodule

// File: doc/pp_reducer.md
# pp_reducer

Partial-product reduction and final-add stage of the pipelined Booth multiplier. It sits directly downstream of the partial-product generator and consumes its sixteen pre-shifted 64-bit partial products over the same valid/ready handshake. The block compresses them through a registered carry-save tree and a final carry-propagate adder, then presents the 64-bit product. It is a 3-stage, bubble-collapsing pipeline with full backpressure and a throughput of one product per cycle.

## Interface
- WIDTH, 64, datapath width of every partial product and of the product; only 64 is supported.
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- valid_i  input  1  pp0..pp15 valid (from generator valid_o)
- ready_o  output  1  stage 1 can accept (to generator ready_i)
- pp0..pp15  input  64 each  partial products, already sign-extended and shifted left by 2·k
- valid_o  output  1  product valid
- ready_i  input  1  downstream accepts product
- product  output  64  sum of pp0..pp15, modulo 2^64

## Operation
- All arithmetic is modulo 2^64.
  - 3:2 CSA: sum = a^b^c; carry = ((a&b)|(a&c)|(b&c))<<1, with bit 63 of the pre-shift carry dropped.
  - No sign handling beyond that; the inputs are already two's-complement 64-bit values.
- Stage 1 (comb into reg S1): Wallace levels 16→11→8→6→4. Registers four 64-bit vectors plus v1.
- Stage 2 (comb into reg S2): 4→3→2. Registers sum and carry plus v2.
- Stage 3 (comb into reg S3): product = sum + carry, a 64-bit add with carry-out discarded. Registers product plus v3.
- valid_o = v3. product = S3 register.
- Handshake, per stage k with downstream ready r_k:
  - r_3 = ready_i; r_2 = ~v3 | r_3; r_1 = ~v2 | r_2; ready_o = ~v1 | r_1.
  - Stage k loads data and sets vk ← upstream valid when its enable (~vk | r_k) is high.
  - Stage k holds data and vk when its enable is low.
  - Data registers load only when the upstream valid is also high, so bubbles cause no spurious data toggling.
- Transfer occurs on a cycle with valid_i & ready_o (input side) or valid_o & ready_i (output side).
- While valid_o & ~ready_i, product and valid_o stay stable.
- Ordering is strictly FIFO. Nothing is dropped or duplicated.
- Capacity is 3 transactions in flight. Once full with ready_i low, ready_o is low.
- ready_o depends combinationally on ready_i and the stage valids. There is no combinational path from valid_i to ready_o.

## Timing
- Reset, async on rst high: v1 = v2 = v3 = 0, valid_o = 0, product = 0, all pipeline data registers = 0.
- While rst is high, ready_o = 1, because the stages are empty.
- Reset mid-operation discards all in-flight transactions. The first cycle after rst falls behaves as empty.
- Latency: an input accepted at edge N produces valid_o high after edge N+2 (three register stages). This holds with ready_i high throughout.
- Throughput: 1 per cycle with ready_i held high. Back-to-back inputs produce back-to-back outputs.
- Bubbles collapse: a stall at stage 3 still allows accepting into empty stages 1–2. ready_o falls only when all three stages are valid and ready_i is low.
- Simultaneous accept and emit while full (ready_i high): all stages advance in the same cycle, and ready_o stays high.

## Test plan
- Single transaction: pp0 = 3, pp1 = 20, others 0, ready_i = 1, pulse valid_i one cycle -> valid_o high exactly 3 cycles later for 1 cycle with product = 23.
- Signed / wrap: pp0 = 64'hFFFF_FFFF_FFFF_FFFF, pp1 = 4 -> product = 3. All sixteen pp = 64'h8000_0000_0000_0000 -> product = 0.
- Booth end-to-end: pp set for 32'hFFFF_FFFF × 32'h0000_0007 (from the generator model) -> product = 64'hFFFF_FFFF_FFFF_FFF9. Random signed operands, 10k vectors, match the reference multiply.
- Backpressure: ready_i = 0, offer 4 consecutive transactions (products 1, 2, 3, 4) -> exactly 3 accepted and ready_o low on the 4th cycle. product holds at 1 while stalled. After ready_i rises, outputs are 1, 2, 3, 4 in order with no loss or duplicates.
- Throughput / bubbles: 8 back-to-back inputs with ready_i random 50% -> every input emitted once, in order. ready_o low only when v1 & v2 & v3 & ~ready_i.
- Reset mid-flight: 2 transactions in flight, assert rst asynchronously between edges -> valid_o and product go to 0 immediately. After release, no stale output appears, and a new transaction emerges with correct latency 3.
